// File: rtl/spell_sram_bridge_if.sv
// Wishbone-classic bus between the spell SRAM bridge (master) and the OpenRAM wrapper (slave).
// Signal suffixes are relative to the master side.
interface spell_sram_bridge_if;
   logic        sram_cyc_o;
   logic        sram_stb_o;
   logic        sram_we_o;
   logic [3:0]  sram_sel_o;
   logic [31:0] sram_adr_o;
   logic [31:0] sram_dat_o;
   logic [31:0] sram_dat_i;
   logic        sram_ack_i;

   modport master (
      output sram_cyc_o, sram_stb_o, sram_we_o, sram_sel_o, sram_adr_o, sram_dat_o,
      input  sram_dat_i, sram_ack_i
   );

   modport slave (
      input  sram_cyc_o, sram_stb_o, sram_we_o, sram_sel_o, sram_adr_o, sram_dat_o,
      output sram_dat_i, sram_ack_i
   );
endinterface

// File: rtl/spell_sram_bridge.sv
// Byte-request to 32-bit Wishbone bridge for the spell core, with a one-word read cache
// and an ack timeout that raises a sticky bus_error.
module spell_sram_bridge #(
   parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                sram_enable,
   input  logic                select,
   input  logic [7:0]          addr,
   input  logic [7:0]          data_in,
   input  logic                write,
   output logic [7:0]          data_out,
   output logic                data_ready,
   output logic                bus_error,
   input  logic                err_clear,
   spell_sram_bridge_if.master wb
);

   typedef enum logic [1:0] {IDLE, BUS, DONE, REARM} state_e;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e      state_q;
   logic [7:0]  addr_q;
   logic        cyc_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [31:0] adr_q;
   logic [31:0] dat_q;
   logic [15:0] timer_q;
   logic [7:0]  data_out_q;
   logic        data_ready_q;
   logic        bus_error_q;
   logic        valid_q;
   logic [5:0]  tag_q;
   logic [31:0] cache_q;
   logic [31:0] cache_d;
   logic        cache_we;
   logic        ack_seen;

   function automatic logic [7:0] lane(input logic [31:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

   assign ack_seen = (state_q == BUS) && cyc_q && wb.sram_ack_i;

   // A completed read refills the whole word; a completed write patches only its lane,
   // and only when it targets the word currently cached.
   // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      cache_we = 1'b0;
      cache_d  = cache_q;
      if (ack_seen) begin
         if (!we_q) begin
            cache_we = 1'b1;
            cache_d  = wb.sram_dat_i;
         end else if (valid_q && (tag_q == addr_q[7:2])) begin
            cache_we = 1'b1;
            cache_d[{addr_q[1:0], 3'b000} +: 8] = dat_q[7:0];
         end
      end
   end

   // NOTE: the cache word has no reset; valid_q gates every use of it, so its power-up
   // contents never reach an output.
   always_ff @(posedge clock) begin
      if (cache_we) cache_q <= cache_d;
   end

   // NOTE: sequential state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         adr_q        <= '0;
         dat_q        <= '0;
         timer_q      <= '0;
         data_out_q   <= '0;
         data_ready_q <= 1'b0;
         bus_error_q  <= 1'b0;
         valid_q      <= 1'b0;
         tag_q        <= '0;
      end else begin
         data_ready_q <= 1'b0;
         if (err_clear) bus_error_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (select) begin
                  addr_q <= addr;
                  if (!sram_enable) begin
                     data_out_q <= '0;
                     valid_q    <= 1'b0;
                     state_q    <= DONE;
                  end else if (!write && valid_q && (tag_q == addr[7:2])) begin
                     data_out_q <= lane(cache_q, addr[1:0]);
                     state_q    <= DONE;
                  end else begin
                     we_q    <= write;
                     sel_q   <= write ? (4'b0001 << addr[1:0]) : 4'b1111;
                     adr_q   <= BASE_ADDR + {22'b0, addr[7:2], 2'b00};
                     dat_q   <= {4{data_in}};
                     timer_q <= '0;
                     state_q <= BUS;
                  end
               end
            end

            // First BUS cycle raises cyc; ack is only honoured once cyc is visible.
            BUS: begin
               if (!cyc_q) begin
                  cyc_q <= 1'b1;
               end else if (wb.sram_ack_i) begin
                  cyc_q   <= 1'b0;
                  state_q <= DONE;
                  if (!we_q) begin
                     data_out_q <= lane(wb.sram_dat_i, addr_q[1:0]);
                     tag_q      <= addr_q[7:2];
                     valid_q    <= sram_enable;
                  end else if (!sram_enable) begin
                     valid_q <= 1'b0;
                  end
               end else if (timer_q == TIMER_LAST) begin
                  cyc_q       <= 1'b0;
                  bus_error_q <= 1'b1;
                  data_out_q  <= 8'hFF;
                  valid_q     <= 1'b0;
                  state_q     <= DONE;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end

            DONE: begin
               data_ready_q <= 1'b1;
               state_q      <= REARM;
            end

            REARM: begin
               if (!select) state_q <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_out      = data_out_q;
   assign data_ready    = data_ready_q;
   assign bus_error     = bus_error_q;
   assign wb.sram_cyc_o = cyc_q;
   assign wb.sram_stb_o = cyc_q;
   assign wb.sram_we_o  = we_q;
   assign wb.sram_sel_o = sel_q;
   assign wb.sram_adr_o = adr_q;
   assign wb.sram_dat_o = dat_q;

endmodule

// File: tb/tb_spell_sram_bridge.sv
// Self-checking bench for spell_sram_bridge: Wishbone slave model with programmable wait
// states, byte-level reference memory and a one-word cache model for hit/miss prediction.
module tb_spell_sram_bridge;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int          TMO  = 4;

   logic       clock       = 1'b0;
   logic       reset_n     = 1'b0;
   logic       sram_enable = 1'b1;
   logic       select      = 1'b0;
   logic [7:0] addr        = '0;
   logic [7:0] data_in     = '0;
   logic       write       = 1'b0;
   logic       err_clear   = 1'b0;
   logic [7:0] data_out;
   logic       data_ready;
   logic       bus_error;

   always #5 clock = ~clock;

   spell_sram_bridge_if wb_if ();

   spell_sram_bridge #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .sram_enable (sram_enable),
      .select      (select),
      .addr        (addr),
      .data_in     (data_in),
      .write       (write),
      .data_out    (data_out),
      .data_ready  (data_ready),
      .bus_error   (bus_error),
      .err_clear   (err_clear),
      .wb          (wb_if.master)
   );

   int checks = 0;
   int errors = 0;

   // Slave model and reference data
   logic [31:0] mem [64];
   logic [7:0]  ref_bytes [256];
   bit          ref_valid = 1'b0;
   logic [5:0]  ref_tag   = '0;
   int          ack_delay = 1;
   bit          slv_mute  = 1'b0;
   int          wait_cnt  = 0;
   int          bus_starts = 0;
   bit          cyc_prev  = 1'b0;
   logic        slv_ack   = 1'b0;
   logic [31:0] slv_dat   = '0;

   assign wb_if.sram_ack_i = slv_ack;
   assign wb_if.sram_dat_i = slv_dat;

   always @(negedge clock) begin
      logic [31:0] off;
      logic [5:0]  idx;
      if (wb_if.sram_cyc_o && wb_if.sram_stb_o) begin
         if (!cyc_prev) bus_starts++;
         wait_cnt++;
         off = wb_if.sram_adr_o - BASE;
         idx = off[7:2];
         if (!slv_mute && wait_cnt >= ack_delay) begin
            slv_ack = 1'b1;
            slv_dat = mem[idx];
            if (wb_if.sram_we_o)
               for (int l = 0; l < 4; l++)
                  if (wb_if.sram_sel_o[l]) mem[idx][8*l +: 8] = wb_if.sram_dat_o[8*l +: 8];
         end else begin
            slv_ack = 1'b0;
         end
      end else begin
         wait_cnt = 0;
         slv_ack  = 1'b0;
      end
      cyc_prev = wb_if.sram_cyc_o;
   end

   task automatic set_word(input int w, input logic [31:0] v);
      mem[w] = v;
      for (int l = 0; l < 4; l++) ref_bytes[4*w + l] = v[8*l +: 8];
   endtask

   // Request results
   logic [7:0]  r_dout;
   int          r_lat, r_nbus, r_cyc_cnt, r_extra;
   logic [31:0] r_adr, r_dat;
   logic [3:0]  r_sel;
   logic        r_we;
   bit          r_err_seen, r_got;

   // Issues one request, holds select for `hold` extra cycles after completion, then drops it.
   task automatic do_req(input logic [7:0] a, input logic w, input logic [7:0] d, input int hold);
      int starts0;
      bit seen_cyc;
      @(posedge clock); #1;
      addr = a; write = w; data_in = d; select = 1'b1;
      starts0 = bus_starts; seen_cyc = 0; r_cyc_cnt = 0; r_err_seen = 0; r_got = 0;
      r_lat = -1; r_extra = 0; r_adr = '0; r_sel = '0; r_we = 1'b0; r_dat = '0; r_dout = '0;
      for (int i = 1; i <= 40 && !r_got; i++) begin
         @(posedge clock); #1;
         if (wb_if.sram_cyc_o) begin
            if (!seen_cyc) begin
               r_adr = wb_if.sram_adr_o; r_sel = wb_if.sram_sel_o;
               r_we  = wb_if.sram_we_o;  r_dat = wb_if.sram_dat_o;
            end
            seen_cyc = 1;
            r_cyc_cnt++;
         end
         if (bus_error) r_err_seen = 1;
         if (data_ready) begin
            r_got = 1; r_lat = i - 1; r_dout = data_out;
         end
      end
      checks++;
      if (!r_got) begin
         errors++;
         $display("FAIL req_timeout: addr=%h no data_ready within 40 cycles", a);
      end
      for (int i = 0; i <= hold; i++) begin
         @(posedge clock); #1;
         if (data_ready) r_extra++;
      end
      select = 1'b0;
      r_nbus = bus_starts - starts0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (wb_if.sram_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", wb_if.sram_cyc_o); end
      checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", data_ready); end
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_error); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", data_out); end
      checks++; if ({wb_if.sram_sel_o, wb_if.sram_adr_o} !== 36'h0) begin errors++; $display("FAIL reset_bus: sel=%h adr=%h want 0", wb_if.sram_sel_o, wb_if.sram_adr_o); end
      @(posedge clock); #1;
      reset_n = 1'b1;
      ref_valid = 0;
      repeat (2) @(posedge clock);
   endtask

   task automatic test_read_miss();
      set_word(1, 32'hDDCCBBAA);
      ack_delay = 2;
      do_req(8'h05, 1'b0, 8'h00, 0);
      checks++; if (r_adr !== BASE + 32'd4) begin errors++; $display("FAIL miss_adr: got %h want %h", r_adr, BASE + 32'd4); end
      checks++; if (r_sel !== 4'hF || r_we !== 1'b0) begin errors++; $display("FAIL miss_sel: got sel=%h we=%b want F 0", r_sel, r_we); end
      checks++; if (r_dout !== 8'hBB) begin errors++; $display("FAIL miss_data: got %h want BB", r_dout); end
      checks++; if (r_lat !== 4) begin errors++; $display("FAIL miss_latency: got %0d want 4", r_lat); end
      checks++; if (r_extra !== 0 || r_nbus !== 1) begin errors++; $display("FAIL miss_pulse: extra=%0d bus=%0d want 0 1", r_extra, r_nbus); end
      ref_valid = 1; ref_tag = 6'd1;
   endtask

   task automatic test_read_hit();
      do_req(8'h07, 1'b0, 8'h00, 0);
      checks++; if (r_dout !== 8'hDD) begin errors++; $display("FAIL hit_data: got %h want DD", r_dout); end
      checks++; if (r_nbus !== 0 || r_lat !== 1) begin errors++; $display("FAIL hit_timing: bus=%0d lat=%0d want 0 1", r_nbus, r_lat); end
   endtask

   task automatic test_write();
      ack_delay = 1;
      do_req(8'h06, 1'b1, 8'h5A, 0);
      ref_bytes[6] = 8'h5A;
      checks++; if (r_sel !== 4'b0100 || r_we !== 1'b1) begin errors++; $display("FAIL wr_sel: got sel=%b we=%b want 0100 1", r_sel, r_we); end
      checks++; if (r_dat !== 32'h5A5A5A5A) begin errors++; $display("FAIL wr_dat: got %h want 5A5A5A5A", r_dat); end
      checks++; if (r_adr !== BASE + 32'd4 || r_nbus !== 1) begin errors++; $display("FAIL wr_bus: adr=%h bus=%0d want %h 1", r_adr, r_nbus, BASE + 32'd4); end
      do_req(8'h06, 1'b0, 8'h00, 0);
      checks++; if (r_dout !== 8'h5A || r_nbus !== 0) begin errors++; $display("FAIL wr_rehit: got %h bus=%0d want 5A 0", r_dout, r_nbus); end
   endtask

   task automatic test_disabled();
      sram_enable = 1'b0;
      do_req(8'h05, 1'b0, 8'h00, 0);
      checks++; if (r_dout !== 8'h00 || r_nbus !== 0 || r_lat !== 1) begin errors++; $display("FAIL dis_req: got %h bus=%0d lat=%0d want 00 0 1", r_dout, r_nbus, r_lat); end
      ref_valid = 0;
      sram_enable = 1'b1;
      do_req(8'h07, 1'b0, 8'h00, 0);
      checks++; if (r_nbus !== 1 || r_dout !== ref_bytes[7]) begin errors++; $display("FAIL dis_invalidate: bus=%0d got %h want 1 %h", r_nbus, r_dout, ref_bytes[7]); end
      ref_valid = 1; ref_tag = 6'd1;
   endtask

   task automatic test_timeout();
      slv_mute = 1'b1;
      do_req(8'h40, 1'b0, 8'h00, 0);
      slv_mute = 1'b0;
      ref_valid = 0;
      checks++; if (r_cyc_cnt !== TMO) begin errors++; $display("FAIL tmo_cycles: got %0d want %0d", r_cyc_cnt, TMO); end
      checks++; if (r_dout !== 8'hFF) begin errors++; $display("FAIL tmo_data: got %h want FF", r_dout); end
      repeat (3) @(posedge clock);
      #1;
      checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", bus_error); end
      err_clear = 1'b1;
      @(posedge clock); #1;
      err_clear = 1'b0;
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", bus_error); end
      do_req(8'h05, 1'b0, 8'h00, 0);
      checks++; if (r_nbus !== 1 || r_dout !== ref_bytes[5]) begin errors++; $display("FAIL tmo_invalidate: bus=%0d got %h want 1 %h", r_nbus, r_dout, ref_bytes[5]); end
      ref_valid = 1; ref_tag = 6'd1;
   endtask

   task automatic test_ack_at_expiry();
      ack_delay = TMO;
      do_req(8'h08, 1'b0, 8'h00, 0);
      checks++; if (r_dout !== ref_bytes[8] || r_err_seen || bus_error !== 1'b0) begin errors++; $display("FAIL expiry_ack: got %h err=%b want %h 0", r_dout, r_err_seen, ref_bytes[8]); end
      checks++; if (r_lat !== 2 + TMO) begin errors++; $display("FAIL expiry_latency: got %0d want %0d", r_lat, 2 + TMO); end
      ref_valid = 1; ref_tag = 6'd2;
      ack_delay = 1;
   endtask

   task automatic test_err_set_wins();
      err_clear = 1'b1;
      slv_mute  = 1'b1;
      do_req(8'h0C, 1'b0, 8'h00, 0);
      slv_mute  = 1'b0;
      ref_valid = 0;
      checks++; if (!r_err_seen || r_dout !== 8'hFF) begin errors++; $display("FAIL set_wins: err_seen=%b got %h want 1 FF", r_err_seen, r_dout); end
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL set_then_clear: got %b want 0", bus_error); end
      err_clear = 1'b0;
   endtask

   task automatic test_select_held();
      do_req(8'h20, 1'b0, 8'h00, 6);
      checks++; if (r_extra !== 0 || r_nbus !== 1) begin errors++; $display("FAIL held_select: extra=%0d bus=%0d want 0 1", r_extra, r_nbus); end
      checks++; if (r_dout !== ref_bytes[8'h20]) begin errors++; $display("FAIL held_data: got %h want %h", r_dout, ref_bytes[8'h20]); end
      ref_valid = 1; ref_tag = 6'd8;
   endtask

   task automatic test_reset_mid_bus();
      bit seen;
      do_req(8'h07, 1'b0, 8'h00, 0);
      slv_mute = 1'b1;
      @(posedge clock); #1;
      addr = 8'h05; write = 1'b1; data_in = 8'h33; select = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge clock); #1;
         if (wb_if.sram_cyc_o) seen = 1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL rst_bus_start: cyc never rose"); end
      @(posedge clock); #3;
      reset_n = 1'b0;
      #1;
      checks++; if (wb_if.sram_cyc_o !== 1'b0 || wb_if.sram_stb_o !== 1'b0) begin errors++; $display("FAIL rst_async_cyc: cyc=%b stb=%b want 0 0", wb_if.sram_cyc_o, wb_if.sram_stb_o); end
      checks++; if (data_ready !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL rst_async_out: ready=%b dout=%h want 0 00", data_ready, data_out); end
      select = 1'b0; write = 1'b0; slv_mute = 1'b0;
      ref_valid = 0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      do_req(8'h07, 1'b0, 8'h00, 0);
      checks++; if (r_nbus !== 1 || r_dout !== ref_bytes[7]) begin errors++; $display("FAIL rst_cache_miss: bus=%0d got %h want 1 %h", r_nbus, r_dout, ref_bytes[7]); end
      ref_valid = 1; ref_tag = 6'd1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [7:0] a, d;
         logic       w;
         bit         hit;
         a = 8'($urandom_range(0, 15));
         d = 8'($urandom);
         w = ($urandom_range(0, 9) < 3);
         ack_delay = $urandom_range(1, 3);
         hit = !w && ref_valid && (ref_tag == a[7:2]);
         do_req(a, w, d, $urandom_range(0, 2));
         checks++; if (r_nbus !== (hit ? 0 : 1)) begin errors++; $display("FAIL rnd_bus[%0d]: addr=%h got %0d want %0d", n, a, r_nbus, hit ? 0 : 1); end
         checks++; if (r_lat !== (hit ? 1 : 2 + ack_delay)) begin errors++; $display("FAIL rnd_lat[%0d]: addr=%h got %0d want %0d", n, a, r_lat, hit ? 1 : 2 + ack_delay); end
         if (w) begin
            ref_bytes[a] = d;
            checks++; if (r_sel !== (4'b0001 << a[1:0])) begin errors++; $display("FAIL rnd_wsel[%0d]: got %b", n, r_sel); end
         end else begin
            checks++; if (r_dout !== ref_bytes[a]) begin errors++; $display("FAIL rnd_rdata[%0d]: addr=%h got %h want %h", n, a, r_dout, ref_bytes[a]); end
            ref_valid = 1; ref_tag = a[7:2];
         end
      end
   endtask

   initial begin
      for (int w = 0; w < 64; w++) set_word(w, $urandom);
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write();
      test_disabled();
      test_timeout();
      test_ack_at_expiry();
      test_err_set_wins();
      test_select_held();
      test_reset_mid_bus();
      test_random();
      repeat (2) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
